// File: rtl/alt_mlab_fifo_pkg.sv
// Shared constants and pointer helper for the MLAB-backed showahead FIFO.
//   ADDR_WIDTH_DFLT : default MLAB address width
//   DEPTH / PTR_W   : words per MLAB and pointer width (address + wrap bit)
//   MAX_WR_LAT      : largest supported write-to-read commit latency
//   ptr_diff()      : modular pointer difference truncated to a given width
package alt_mlab_fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DFLT = 5;
  localparam int unsigned DEPTH           = 2 ** ADDR_WIDTH_DFLT;
  localparam int unsigned PTR_W           = ADDR_WIDTH_DFLT + 1;
  localparam int unsigned MAX_WR_LAT      = 7;
  localparam int unsigned PTR_MAX_W       = 16;

  // (a - b) mod 2**w; callers zero-extend their pointers to PTR_MAX_W bits
  function automatic logic [PTR_MAX_W-1:0] ptr_diff(input logic [PTR_MAX_W-1:0] a,
                                                    input logic [PTR_MAX_W-1:0] b,
                                                    input int unsigned          w);
    logic [PTR_MAX_W-1:0] mask;
    mask = PTR_MAX_W'((33'd1 << w) - 33'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/alt_mlab_fifo_ctrl.sv
// Showahead FIFO controller around one external alt_mlab array.
// Ports:
//   clk, arst               : clock (also MLAB wclk) and async active-high reset
//   din/din_valid/din_ready : push side handshake
//   dout/dout_valid/dout_ready : pop side handshake, dout registered
//   level                   : words in MLAB plus output register
//   mlab_wena/waddr/wdata   : registered MLAB write port
//   mlab_raddr/mlab_rdata   : MLAB read address and combinational read data
module alt_mlab_fifo_ctrl
  import alt_mlab_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DFLT,
  parameter int unsigned WR_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  mlab_wena,
  output logic [ADDR_WIDTH-1:0] mlab_waddr,
  output logic [WIDTH-1:0]      mlab_wdata,
  output logic [ADDR_WIDTH-1:0] mlab_raddr,
  input  logic [WIDTH-1:0]      mlab_rdata
);

  localparam int unsigned N_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned P_W     = ADDR_WIDTH + 1;
  // keep the commit pipe inside the supported 2..MAX_WR_LAT range
  localparam int unsigned LAT     = (WR_LAT > MAX_WR_LAT) ? MAX_WR_LAT :
                                    ((WR_LAT < 2) ? 2 : WR_LAT);

  logic [P_W-1:0]   wptr, cptr, rptr;
  logic [LAT-2:0]   commit_sr;

  logic             push, load, pop, commit_done;
  logic [P_W-1:0]   wptr_nxt, cptr_nxt, rptr_nxt, occ_nxt, level_nxt;
  logic [LAT-1:0]   sr_in;
  logic             dout_valid_nxt, din_ready_nxt;
  logic [WIDTH-1:0] dout_nxt, wdata_nxt;
  logic [ADDR_WIDTH-1:0] waddr_nxt;

  // Handshake decode and next-state computation
  always_comb begin
    push           = 1'b0;
    load           = 1'b0;
    pop            = 1'b0;
    commit_done    = 1'b0;
    sr_in          = '0;
    wptr_nxt       = wptr;
    cptr_nxt       = cptr;
    rptr_nxt       = rptr;
    occ_nxt        = '0;
    level_nxt      = '0;
    dout_valid_nxt = dout_valid;
    din_ready_nxt  = 1'b0;
    dout_nxt       = dout;
    waddr_nxt      = mlab_waddr;
    wdata_nxt      = mlab_wdata;

    push = din_valid && din_ready;
    pop  = dout_valid && dout_ready;
    load = (cptr != rptr) && (!dout_valid || dout_ready);

    // mlab_wena is the first commit stage; commit_sr supplies the remaining LAT-1
    sr_in       = {commit_sr, mlab_wena};
    commit_done = commit_sr[LAT-2];

    wptr_nxt = wptr + P_W'(push);
    cptr_nxt = cptr + P_W'(commit_done);
    rptr_nxt = rptr + P_W'(load);

    if (push) begin
      waddr_nxt = wptr[ADDR_WIDTH-1:0];
      wdata_nxt = din;
    end

    if (load) begin
      dout_nxt       = mlab_rdata;
      dout_valid_nxt = 1'b1;
    end else if (pop) begin
      dout_valid_nxt = 1'b0;
    end

    // level and din_ready are registered from next-state pointers so they track
    // the current pointer state with no extra cycle of lag
    occ_nxt       = P_W'(ptr_diff(PTR_MAX_W'(wptr_nxt), PTR_MAX_W'(rptr_nxt), P_W));
    din_ready_nxt = occ_nxt < P_W'(N_WORDS);
    level_nxt     = occ_nxt + P_W'(dout_valid_nxt);
  end

  // State and output registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wptr       <= '0;
      cptr       <= '0;
      rptr       <= '0;
      commit_sr  <= '0;
      mlab_wena  <= 1'b0;
      mlab_waddr <= '0;
      mlab_wdata <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      level      <= '0;
      din_ready  <= 1'b1;
    end else begin
      wptr       <= wptr_nxt;
      cptr       <= cptr_nxt;
      rptr       <= rptr_nxt;
      commit_sr  <= sr_in[LAT-2:0];
      mlab_wena  <= push;
      mlab_waddr <= waddr_nxt;
      mlab_wdata <= wdata_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      level      <= level_nxt;
      din_ready  <= din_ready_nxt;
    end
  end

  assign mlab_raddr = rptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_alt_mlab_fifo_ctrl.sv
// Directed bench for alt_mlab_fifo_ctrl with a behavioural MLAB beside it.
module tb_alt_mlab_fifo_ctrl;

  localparam int unsigned W   = 20;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 3;

  logic          clk;
  logic          arst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   level;
  logic          mlab_wena;
  logic [AW-1:0] mlab_waddr;
  logic [W-1:0]  mlab_wdata;
  logic [AW-1:0] mlab_raddr;
  logic [W-1:0]  mlab_rdata;

  logic [W-1:0]  mem [0:(2**AW)-1];
  logic [W-1:0]  sb_q [$];

  int n_checks;
  int n_fail;

  alt_mlab_fifo_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .WR_LAT(LAT)) dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .mlab_wena  (mlab_wena),
    .mlab_waddr (mlab_waddr),
    .mlab_wdata (mlab_wdata),
    .mlab_raddr (mlab_raddr),
    .mlab_rdata (mlab_rdata)
  );

  // MLAB model: registered write, combinational read
  always @(posedge clk) if (mlab_wena) mem[mlab_waddr] <= mlab_wdata;
  assign mlab_rdata = mem[mlab_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    arst = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    din_valid = 1'b0; din = '0; dout_ready = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    #1;
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got %0b exp 0", dout_valid); end
    n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_checks++; if (mlab_wena !== 1'b0) begin n_fail++; $display("FAIL reset_wena got %0b exp 0", mlab_wena); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", dout); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got %0b exp 1", din_ready); end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    din = 20'hABCDE; din_valid = 1'b1; dout_ready = 1'b1;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %0b exp 1", din_ready); end
    @(negedge clk);                      // edge 0: push accepted
    din_valid = 1'b0;
    n_checks++; if (mlab_wena !== 1'b1) begin n_fail++; $display("FAIL single_wena got %0b exp 1", mlab_wena); end
    n_checks++; if (mlab_waddr !== 5'd0) begin n_fail++; $display("FAIL single_waddr got %0d exp 0", mlab_waddr); end
    n_checks++; if (mlab_wdata !== 20'hABCDE) begin n_fail++; $display("FAIL single_wdata got %h exp abcde", mlab_wdata); end
    n_checks++; if (level !== 6'd1) begin n_fail++; $display("FAIL single_level0 got %0d exp 1", level); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);                    // edges 1..3: still committing
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid edge %0d got %0b exp 0", k, dout_valid); end
      if (k == 1) begin
        n_checks++; if (mlab_wena !== 1'b0) begin n_fail++; $display("FAIL single_wena_drop got %0b exp 0", mlab_wena); end
      end
    end
    @(negedge clk);                      // edge 4: loaded into dout
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", dout_valid); end
    n_checks++; if (dout !== 20'hABCDE) begin n_fail++; $display("FAIL single_dout got %h exp abcde", dout); end
    n_checks++; if (level !== 6'd1) begin n_fail++; $display("FAIL single_level1 got %0d exp 1", level); end
    @(negedge clk);                      // edge 5: popped
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %0b exp 0", dout_valid); end
    n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL single_pop_level got %0d exp 0", level); end
  endtask

  task automatic test_fill();
    int accepted;
    int val;
    do_reset();
    accepted = 0; val = 1;
    for (int cyc = 0; cyc < 200 && accepted < 33; cyc++) begin
      din = W'(val); din_valid = 1'b1;
      if (din_ready) begin accepted++; val++; end
      @(negedge clk);
    end
    din = 20'h99; din_valid = 1'b1;      // held off while full
    repeat (6) @(negedge clk);
    n_checks++; if (accepted !== 33) begin n_fail++; $display("FAIL fill_accepted got %0d exp 33", accepted); end
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %0b exp 0", din_ready); end
    n_checks++; if (level !== 6'd33) begin n_fail++; $display("FAIL fill_level got %0d exp 33", level); end
    n_checks++; if (dout !== 20'd1) begin n_fail++; $display("FAIL fill_dout got %0d exp 1", dout); end
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid got %0b exp 1", dout_valid); end
    din_valid = 1'b0;
  endtask

  task automatic test_full_pop();
    int exp;
    int err;
    din_valid = 1'b0; dout_ready = 1'b1;
    @(negedge clk);                      // one pop while full
    dout_ready = 1'b0;
    n_checks++; if (dout !== 20'd2) begin n_fail++; $display("FAIL fullpop_dout got %0d exp 2", dout); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready got %0b exp 1", din_ready); end
    n_checks++; if (level !== 6'd32) begin n_fail++; $display("FAIL fullpop_level got %0d exp 32", level); end
    din = 20'd34; din_valid = 1'b1;
    @(negedge clk);
    din = 20'd35;                        // must not be accepted
    repeat (3) @(negedge clk);
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL refill_ready got %0b exp 0", din_ready); end
    n_checks++; if (level !== 6'd33) begin n_fail++; $display("FAIL refill_level got %0d exp 33", level); end
    din_valid = 1'b0; dout_ready = 1'b1;
    exp = 2; err = 0;
    for (int cyc = 0; cyc < 100 && exp < 35; cyc++) begin
      if (dout_valid) begin
        if (dout !== W'(exp)) err++;
        exp++;
      end
      @(negedge clk);
    end
    n_checks++; if (err !== 0 || exp !== 35) begin n_fail++; $display("FAIL drain_order errors %0d next %0d exp 0 and 35", err, exp); end
    n_checks++; if (dout_valid !== 1'b0 || level !== 6'd0) begin n_fail++; $display("FAIL drain_empty valid %0b level %0d exp 0 0", dout_valid, level); end
  endtask

  task automatic test_back_to_back();
    int sent, recv, first_c, bubbles, err, wraps;
    logic fire_in, fire_out;
    do_reset();
    dout_ready = 1'b1;
    sent = 0; recv = 0; first_c = -1; bubbles = 0; err = 0; wraps = 0;
    for (int c = 0; c < 300 && recv < 100; c++) begin
      if (mlab_wena && mlab_waddr == 5'd31) wraps++;
      din_valid = (sent < 100);
      din       = W'(sent);
      fire_in   = din_valid && din_ready;
      fire_out  = dout_valid && dout_ready;
      if (fire_out) begin
        if (dout !== W'(recv)) err++;
        if (first_c < 0) first_c = c;
        recv++;
      end else if (recv > 0) begin
        bubbles++;
      end
      if (fire_in) sent++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    n_checks++; if (recv !== 100 || err !== 0) begin n_fail++; $display("FAIL stream_data recv %0d errors %0d exp 100 0", recv, err); end
    n_checks++; if (first_c !== int'(LAT) + 2) begin n_fail++; $display("FAIL stream_latency got %0d exp %0d", first_c, LAT + 2); end
    n_checks++; if (bubbles !== 0) begin n_fail++; $display("FAIL stream_bubbles got %0d exp 0", bubbles); end
    n_checks++; if (wraps !== 3) begin n_fail++; $display("FAIL stream_wraps got %0d exp 3", wraps); end
  endtask

  task automatic test_random();
    int pushes, pops, data_err, lvl_err, max_lvl;
    logic fire_in, fire_out;
    logic [W-1:0] exp;
    do_reset();
    sb_q.delete();
    pushes = 0; pops = 0; data_err = 0; lvl_err = 0; max_lvl = 0;
    for (int cyc = 0; cyc < 60000 && pops < 10000; cyc++) begin
      if (int'(level) != pushes - pops) lvl_err++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      din_valid  = (pushes < 10000) && ($urandom_range(0, 1) == 1);
      din        = W'($urandom);
      dout_ready = ($urandom_range(0, 1) == 1);
      fire_in    = din_valid && din_ready;
      fire_out   = dout_valid && dout_ready;
      if (fire_out) begin
        if (sb_q.size() == 0) data_err++;
        else begin
          exp = sb_q.pop_front();
          if (dout !== exp) data_err++;
        end
        pops++;
      end
      if (fire_in) begin
        sb_q.push_back(din);
        pushes++;
      end
      @(negedge clk);
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    n_checks++; if (pops !== 10000) begin n_fail++; $display("FAIL random_count got %0d exp 10000", pops); end
    n_checks++; if (data_err !== 0) begin n_fail++; $display("FAIL random_data errors %0d exp 0", data_err); end
    n_checks++; if (lvl_err !== 0) begin n_fail++; $display("FAIL random_level errors %0d exp 0", lvl_err); end
    n_checks++; if (max_lvl > 33) begin n_fail++; $display("FAIL random_max_level got %0d exp <=33", max_lvl); end
  endtask

  task automatic test_arst_mid();
    logic got;
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = W'(32'h100 + i); din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (level !== 6'd5) begin n_fail++; $display("FAIL arst_pre_level got %0d exp 5", level); end
    din = 20'h105; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n_checks++; if (mlab_wena !== 1'b1) begin n_fail++; $display("FAIL arst_inflight got %0b exp 1", mlab_wena); end
    arst = 1'b1;
    #1;
    n_checks++; if (dout_valid !== 1'b0 || dout !== '0) begin n_fail++; $display("FAIL arst_dout valid %0b data %h exp 0 0", dout_valid, dout); end
    n_checks++; if (level !== '0) begin n_fail++; $display("FAIL arst_level got %0d exp 0", level); end
    n_checks++; if (mlab_wena !== 1'b0 || mlab_waddr !== '0 || mlab_wdata !== '0) begin n_fail++; $display("FAIL arst_wport wena %0b waddr %0d wdata %h exp 0 0 0", mlab_wena, mlab_waddr, mlab_wdata); end
    n_checks++; if (mlab_raddr !== '0) begin n_fail++; $display("FAIL arst_raddr got %0d exp 0", mlab_raddr); end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    din = 20'h55; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      if (dout_valid) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL arst_fresh_timeout got %0b exp 1", got); end
    n_checks++; if (dout !== 20'h55) begin n_fail++; $display("FAIL arst_fresh_dout got %h exp 55", dout); end
    n_checks++; if (level !== 6'd1) begin n_fail++; $display("FAIL arst_fresh_level got %0d exp 1", level); end
    dout_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (dout_valid !== 1'b0 || level !== 6'd0) begin n_fail++; $display("FAIL arst_stale valid %0b level %0d exp 0 0", dout_valid, level); end
    dout_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    arst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_arst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
